// File: rtl/clock_set_ctrl.sv
// Digital clock with BCD time keeping, field editing, alarm and hourly chime.
// Key pulses step an edit FSM; all display/status outputs are registered.
module clock_set_ctrl #(
    parameter int unsigned CLK_DIV    = 50_000_000,
    parameter int unsigned HOURLY_SEC = 5,
    parameter int unsigned ALARM_SEC  = 30
) (
    input  logic        clk,
    input  logic        rst_N,
    input  logic        key_mode,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic        disp_on,
    output logic [23:0] number_BCD,
    output logic [2:0]  DTube_en,
    output logic [2:0]  Twinkle_en,
    output logic        HOURLY,
    output logic        ALARM
);

    localparam int unsigned PW  = 26;
    localparam int unsigned ACW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
    localparam logic [PW-1:0]  PRESC_TC = PW'(CLK_DIV - 1);
    localparam logic [ACW-1:0] ALM_TC   = ACW'(ALARM_SEC - 1);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        SET_H = 3'd1,
        SET_M = 3'd2,
        SET_S = 3'd3,
        ALM_H = 3'd4,
        ALM_M = 3'd5
    } state_t;

    state_t         state, state_nxt;
    logic [7:0]     hh, mm, ss, alm_hh, alm_mm;
    logic [7:0]     hh_nxt, mm_nxt, ss_nxt, alm_hh_nxt, alm_mm_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [ACW-1:0] alm_cnt, alm_cnt_nxt;
    logic           alarm_nxt;
    logic           hour_seen, hour_seen_nxt;

    logic [23:0]    number_nxt;
    logic [2:0]     dtube_nxt, twinkle_nxt;
    logic           hourly_nxt;
    logic [6:0]     ss_bin_nxt;

    logic           tick, key_any, consume, mode_go, adj_inc, adj_dec;

    // BCD increment/decrement wrapping between 00 and top
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
        if (v == 8'h00)
            return top;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // A key pulse that silences the alarm is swallowed entirely
    assign tick    = (state == RUN) && (presc == PRESC_TC);
    assign key_any = key_mode | key_inc | key_dec;
    assign consume = ALARM & key_any;
    assign mode_go = key_mode & ~consume;
    assign adj_inc = key_inc & ~key_dec & ~key_mode & ~consume;
    assign adj_dec = key_dec & ~key_inc & ~key_mode & ~consume;

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state      <= RUN;
            hh         <= 8'h00;
            mm         <= 8'h00;
            ss         <= 8'h00;
            alm_hh     <= 8'h07;
            alm_mm     <= 8'h00;
            presc      <= '0;
            alm_cnt    <= '0;
            hour_seen  <= 1'b0;
            number_BCD <= 24'h000000;
            DTube_en   <= 3'b111;
            Twinkle_en <= 3'b000;
            HOURLY     <= 1'b0;
            ALARM      <= 1'b0;
        end else begin
            state      <= state_nxt;
            hh         <= hh_nxt;
            mm         <= mm_nxt;
            ss         <= ss_nxt;
            alm_hh     <= alm_hh_nxt;
            alm_mm     <= alm_mm_nxt;
            presc      <= presc_nxt;
            alm_cnt    <= alm_cnt_nxt;
            hour_seen  <= hour_seen_nxt;
            number_BCD <= number_nxt;
            DTube_en   <= dtube_nxt;
            Twinkle_en <= twinkle_nxt;
            HOURLY     <= hourly_nxt;
            ALARM      <= alarm_nxt;
        end
    end

    always_comb begin : next_state
        state_nxt     = state;
        hh_nxt        = hh;
        mm_nxt        = mm;
        ss_nxt        = ss;
        alm_hh_nxt    = alm_hh;
        alm_mm_nxt    = alm_mm;
        presc_nxt     = '0;
        alm_cnt_nxt   = alm_cnt;
        alarm_nxt     = ALARM;
        hour_seen_nxt = hour_seen;

        if (mode_go) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                SET_S:   state_nxt = ALM_H;
                ALM_H:   state_nxt = ALM_M;
                default: state_nxt = RUN;
            endcase
        end

        case (state)
            RUN: begin
                if (tick) begin
                    ss_nxt = bcd_inc(ss, 8'h59);
                    if (ss == 8'h59) begin
                        mm_nxt = bcd_inc(mm, 8'h59);
                        if (mm == 8'h59) begin
                            hh_nxt        = bcd_inc(hh, 8'h23);
                            hour_seen_nxt = 1'b1;
                        end
                    end
                end
            end
            SET_H: begin
                if (adj_inc)      hh_nxt = bcd_inc(hh, 8'h23);
                else if (adj_dec) hh_nxt = bcd_dec(hh, 8'h23);
            end
            SET_M: begin
                if (adj_inc)      mm_nxt = bcd_inc(mm, 8'h59);
                else if (adj_dec) mm_nxt = bcd_dec(mm, 8'h59);
            end
            SET_S: begin
                if (adj_inc)      ss_nxt = bcd_inc(ss, 8'h59);
                else if (adj_dec) ss_nxt = bcd_dec(ss, 8'h59);
            end
            ALM_H: begin
                if (adj_inc)      alm_hh_nxt = bcd_inc(alm_hh, 8'h23);
                else if (adj_dec) alm_hh_nxt = bcd_dec(alm_hh, 8'h23);
            end
            ALM_M: begin
                if (adj_inc)      alm_mm_nxt = bcd_inc(alm_mm, 8'h59);
                else if (adj_dec) alm_mm_nxt = bcd_dec(alm_mm, 8'h59);
            end
            default: ;
        endcase

        // Prescaler only runs across consecutive RUN cycles, so re-entry restarts it at 0
        if (state == RUN && state_nxt == RUN)
            presc_nxt = tick ? '0 : presc + PW'(1);

        if (ALARM) begin
            if (consume || state_nxt != RUN) begin
                alarm_nxt = 1'b0;
            end else if (tick) begin
                if (alm_cnt == ALM_TC)
                    alarm_nxt = 1'b0;
                else
                    alm_cnt_nxt = alm_cnt + ACW'(1);
            end
        end
        if (tick && hh_nxt == alm_hh && mm_nxt == alm_mm && ss_nxt == 8'h00) begin
            alarm_nxt   = 1'b1;
            alm_cnt_nxt = '0;
        end
    end

    // Output values are decoded from next-state so they land together with the state change
    always_comb begin : output_decode
        number_nxt  = {hh_nxt, mm_nxt, ss_nxt};
        dtube_nxt   = disp_on ? 3'b111 : 3'b000;
        twinkle_nxt = 3'b000;
        case (state_nxt)
            SET_H: twinkle_nxt = 3'b100;
            SET_M: twinkle_nxt = 3'b010;
            SET_S: twinkle_nxt = 3'b001;
            ALM_H: begin
                twinkle_nxt = 3'b100;
                number_nxt  = {alm_hh_nxt, alm_mm_nxt, 8'h00};
                dtube_nxt   = disp_on ? 3'b110 : 3'b000;
            end
            ALM_M: begin
                twinkle_nxt = 3'b010;
                number_nxt  = {alm_hh_nxt, alm_mm_nxt, 8'h00};
                dtube_nxt   = disp_on ? 3'b110 : 3'b000;
            end
            default: ;
        endcase
        ss_bin_nxt = 7'(ss_nxt[7:4]) * 7'd10 + 7'(ss_nxt[3:0]);
        hourly_nxt = (state_nxt == RUN) && (mm_nxt == 8'h00) &&
                     (32'(ss_bin_nxt) < HOURLY_SEC) && hour_seen_nxt;
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_clock_set_ctrl;

    logic        clk;
    logic        rst_N;
    logic        key_mode, key_inc, key_dec, disp_on;
    logic [23:0] number_BCD;
    logic [2:0]  DTube_en, Twinkle_en;
    logic        HOURLY, ALARM;

    clock_set_ctrl #(
        .CLK_DIV   (4),
        .HOURLY_SEC(2),
        .ALARM_SEC (3)
    ) dut (
        .clk       (clk),
        .rst_N     (rst_N),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .disp_on   (disp_on),
        .number_BCD(number_BCD),
        .DTube_en  (DTube_en),
        .Twinkle_en(Twinkle_en),
        .HOURLY    (HOURLY),
        .ALARM     (ALARM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] num;
        logic [2:0]  dt;
        logic [2:0]  tw;
        logic        h;
        logic        a;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  mon_e;
    string mon_nm;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation tagged with the current cycle
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            n_cmp++;
            if (mon_e.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         mon_nm, mon_e.cyc, cyc);
            end else if ({number_BCD, DTube_en, Twinkle_en, HOURLY, ALARM} !==
                         {mon_e.num, mon_e.dt, mon_e.tw, mon_e.h, mon_e.a}) begin
                n_bad++;
                $display("FAIL %s: got num=%h dt=%b tw=%b hourly=%b alarm=%b, expected num=%h dt=%b tw=%b hourly=%b alarm=%b",
                         mon_nm, number_BCD, DTube_en, Twinkle_en, HOURLY, ALARM,
                         mon_e.num, mon_e.dt, mon_e.tw, mon_e.h, mon_e.a);
            end
        end
    end

    task automatic push(input int c, input string nm, input logic [23:0] num,
                        input logic [2:0] dt, input logic [2:0] tw, input logic h, input logic a);
        exp_t e;
        e.cyc = c; e.num = num; e.dt = dt; e.tw = tw; e.h = h; e.a = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic m, input logic i, input logic d);
        key_mode = m; key_inc = i; key_dec = d;
        @(negedge clk);
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    task automatic stepx(input logic m, input logic i, input logic d, input string nm,
                         input logic [23:0] num, input logic [2:0] dt, input logic [2:0] tw,
                         input logic h, input logic a);
        push(cyc + 1, nm, num, dt, tw, h, a);
        step(m, i, d);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    // From RUN at mm=01, walk the edit states to set 00:00:58 and return to RUN
    task automatic goto_0058(input int ss_decs, input string nm);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (ss_decs) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        stepx(1'b1, 1'b0, 1'b0, nm, 24'h000058, 3'b111, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_N = 1'b0; disp_on = 1'b0;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        @(negedge clk);
        stepx(0, 0, 0, "rst_vals_disp_off", 24'h000000, 3'b111, 3'b000, 0, 0);
        disp_on = 1'b1;
        stepx(0, 0, 0, "rst_vals", 24'h000000, 3'b111, 3'b000, 0, 0);
        rst_N = 1'b1;

        // Mode ring
        stepx(1, 0, 0, "mode_seth", 24'h000000, 3'b111, 3'b100, 0, 0);
        stepx(1, 0, 0, "mode_setm", 24'h000000, 3'b111, 3'b010, 0, 0);
        stepx(1, 0, 0, "mode_sets", 24'h000000, 3'b111, 3'b001, 0, 0);
        stepx(1, 0, 0, "mode_almh", 24'h070000, 3'b110, 3'b100, 0, 0);
        stepx(1, 0, 0, "mode_almm", 24'h070000, 3'b110, 3'b010, 0, 0);
        stepx(1, 0, 0, "mode_run_no_chime", 24'h000000, 3'b111, 3'b000, 0, 0);
        stepx(1, 0, 0, "back_seth", 24'h000000, 3'b111, 3'b100, 0, 0);

        // Hour editing, simultaneous keys, wraps
        stepx(0, 1, 1, "incdec_same", 24'h000000, 3'b111, 3'b100, 0, 0);
        stepx(0, 1, 0, "seth_inc", 24'h010000, 3'b111, 3'b100, 0, 0);
        stepx(0, 0, 1, "seth_dec", 24'h000000, 3'b111, 3'b100, 0, 0);
        stepx(0, 0, 1, "seth_wrap_dec", 24'h230000, 3'b111, 3'b100, 0, 0);
        stepx(0, 1, 0, "seth_wrap_inc", 24'h000000, 3'b111, 3'b100, 0, 0);
        stepx(0, 0, 1, "seth_23", 24'h230000, 3'b111, 3'b100, 0, 0);
        stepx(1, 1, 0, "mode_beats_inc", 24'h230000, 3'b111, 3'b010, 0, 0);
        stepx(0, 0, 1, "setm_wrap", 24'h235900, 3'b111, 3'b010, 0, 0);
        idle(6);
        stepx(0, 0, 0, "setm_no_tick", 24'h235900, 3'b111, 3'b010, 0, 0);
        stepx(1, 0, 0, "sets_enter", 24'h235900, 3'b111, 3'b001, 0, 0);
        stepx(0, 0, 1, "sets_wrap", 24'h235959, 3'b111, 3'b001, 0, 0);
        stepx(1, 0, 0, "almh_view", 24'h070000, 3'b110, 3'b100, 0, 0);
        stepx(1, 0, 0, "almm_view", 24'h070000, 3'b110, 3'b010, 0, 0);

        // Day rollover and hourly chime
        stepx(1, 0, 0, "rollover_start", 24'h235959, 3'b111, 3'b000, 0, 0);
        idle(3);
        stepx(0, 0, 0, "rollover", 24'h000000, 3'b111, 3'b000, 1, 0);
        idle(3);
        stepx(0, 0, 0, "hourly_s1", 24'h000001, 3'b111, 3'b000, 1, 0);
        idle(3);
        stepx(0, 0, 0, "hourly_end", 24'h000002, 3'b111, 3'b000, 0, 0);
        disp_on = 1'b0;
        stepx(0, 0, 0, "disp_off", 24'h000002, 3'b000, 3'b000, 0, 0);
        disp_on = 1'b1;

        // Alarm run 1: alarm 00:01, start 00:00:58, timeout after 3 ticks
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        stepx(0, 0, 1, "sets_58", 24'h000058, 3'b111, 3'b001, 0, 0);
        step(1, 0, 0);
        repeat (6) step(0, 0, 1);
        stepx(0, 0, 1, "almh_dec", 24'h000000, 3'b110, 3'b100, 0, 0);
        step(1, 0, 0);
        stepx(0, 1, 0, "almm_inc", 24'h000100, 3'b110, 3'b010, 0, 0);
        stepx(1, 0, 0, "alarm_arm", 24'h000058, 3'b111, 3'b000, 0, 0);
        idle(3);
        stepx(0, 0, 0, "alarm_59", 24'h000059, 3'b111, 3'b000, 0, 0);
        idle(3);
        stepx(0, 0, 0, "alarm_set", 24'h000100, 3'b111, 3'b000, 0, 1);
        idle(3);
        stepx(0, 0, 0, "alarm_hold1", 24'h000101, 3'b111, 3'b000, 0, 1);
        idle(3);
        stepx(0, 0, 0, "alarm_hold2", 24'h000102, 3'b111, 3'b000, 0, 1);
        idle(3);
        stepx(0, 0, 0, "alarm_timeout", 24'h000103, 3'b111, 3'b000, 0, 0);

        // Alarm run 2: key_inc silences it without touching the time
        goto_0058(5, "run2_arm");
        idle(3);
        stepx(0, 0, 0, "run2_59", 24'h000059, 3'b111, 3'b000, 0, 0);
        idle(3);
        stepx(0, 0, 0, "run2_set", 24'h000100, 3'b111, 3'b000, 0, 1);
        idle(3);
        stepx(0, 0, 0, "run2_hold", 24'h000101, 3'b111, 3'b000, 0, 1);
        stepx(0, 1, 0, "alarm_inc_clear", 24'h000101, 3'b111, 3'b000, 0, 0);

        // Alarm run 3: key_mode silences it and is consumed
        goto_0058(3, "run3_arm");
        idle(7);
        stepx(0, 0, 0, "run3_set", 24'h000100, 3'b111, 3'b000, 0, 1);
        stepx(1, 0, 0, "alarm_mode_consumed", 24'h000100, 3'b111, 3'b000, 0, 0);
        stepx(1, 0, 0, "mode_after_consume", 24'h000100, 3'b111, 3'b100, 0, 0);

        // Build 12:34:56 in SET_S, then reset mid-edit
        repeat (11) step(0, 1, 0);
        stepx(0, 1, 0, "seth_12", 24'h120100, 3'b111, 3'b100, 0, 0);
        step(1, 0, 0);
        repeat (32) step(0, 1, 0);
        stepx(0, 1, 0, "setm_34", 24'h123400, 3'b111, 3'b010, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 1);
        stepx(0, 0, 1, "sets_56", 24'h123456, 3'b111, 3'b001, 0, 0);

        @(posedge clk);
        #1;
        rst_N = 1'b0;
        push(cyc, "rst_async", 24'h000000, 3'b111, 3'b000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_N = 1'b1;
        idle(2);
        stepx(0, 0, 0, "rst_pre_tick", 24'h000000, 3'b111, 3'b000, 0, 0);
        stepx(0, 0, 0, "rst_first_tick", 24'h000001, 3'b111, 3'b000, 0, 0);

        idle(2);
        while (exp_q.size() != 0) begin
            mon_nm = name_q.pop_front();
            void'(exp_q.pop_front());
            n_cmp++;
            n_bad++;
            $display("FAIL %s: expectation never checked", mon_nm);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
